// File: rtl/apb_exe_unit_2.sv
// APB slave around a 4-op execution unit: a write runs the op selected by PADDR[1:0]
// on the two packed operands in PWDATA; a later read returns the registered result.
module apb_exe_unit_2 #(
    parameter int SEL_WIDTH  = 3,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int SEL_BIT    = 0
) (
    input  logic                  i_PCLK,
    input  logic                  i_PRESETn,
    input  logic [SEL_WIDTH-1:0]  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic [DATA_WIDTH-1:0] o_PRDATA,
    output logic [3:0]            o_PSLVERR
);

    localparam int OW = DATA_WIDTH / 2;
    localparam logic [OW-1:0] SHMAX = OW'(OW - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                r_state, w_next;
    logic                  r_proto;
    logic                  r_valid;
    logic [OW-1:0]         r_res;
    logic [1:0]            r_flags;
    logic                  r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [3:0]            r_pslverr;

    logic                  w_sel;
    logic [1:0]            w_op;
    logic [OW-1:0]         w_a, w_b, w_neg, w_res;
    logic [OW-2:0]         w_shv;
    logic [1:0]            w_flg;
    logic                  w_unused_ok;

    assign w_sel       = i_PSEL[SEL_BIT];
    assign w_op        = i_PADDR[1:0];
    assign w_a         = i_PWDATA[OW-1:0];
    assign w_b         = i_PWDATA[DATA_WIDTH-1:OW];
    assign w_neg       = -w_a;
    assign w_shv       = w_a[OW-2:0] << w_b;
    assign w_unused_ok = &{1'b0, i_PSEL, i_PADDR};

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_sel) w_next = i_PENABLE ? S_ACCESS : S_SETUP;
            S_SETUP: begin
                if (!w_sel)         w_next = S_IDLE;
                else if (i_PENABLE) w_next = S_ACCESS;
            end
            S_ACCESS: w_next = S_DONE;
            S_DONE:   if (!w_sel || !i_PENABLE) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath evaluated straight from the bus; only captured on a write in ACCESS.
    always_comb begin
        w_res = '0;
        w_flg = '0;
        case (w_op)
            2'b00: begin
                if (w_a[OW-1]) begin
                    // Most-negative input: |A| wraps to 100..0, magnitude field is 0.
                    w_res    = {1'b1, w_neg[OW-2:0]};
                    w_flg[0] = ~|w_a[OW-2:0];
                end else begin
                    w_res = w_a;
                end
            end
            2'b01: begin
                w_res[OW-1] = w_a[OW-1];
                if (w_b >= SHMAX) w_flg[1] = 1'b1;
                else              w_res[OW-2:0] = w_shv;
                for (int i = 0; i < OW - 1; i++) begin
                    if ((i + int'(w_b)) >= OW - 1 && (w_a[i] != w_a[OW-1])) w_flg[0] = 1'b1;
                end
            end
            2'b10: w_res[0] = ($signed(w_a) > $signed(w_b));
            default: begin
                for (int i = 0; i < OW; i++) w_res = w_res + {{(OW-1){1'b0}}, w_a[i]};
            end
        endcase
    end

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            r_state   <= S_IDLE;
            r_proto   <= 1'b0;
            r_valid   <= 1'b0;
            r_res     <= '0;
            r_flags   <= '0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= '0;
        end else begin
            r_state   <= w_next;
            r_pready  <= 1'b0;
            r_pslverr <= '0;
            // Only IDLE decides whether this transfer skipped its setup phase.
            if (r_state == S_IDLE) r_proto <= w_sel & i_PENABLE;
            if (r_state == S_ACCESS && w_sel) begin
                r_pready <= 1'b1;
                if (i_PWRITE) begin
                    if (r_proto) begin
                        r_pslverr <= 4'b0100;
                    end else begin
                        r_res     <= w_res;
                        r_flags   <= w_flg;
                        r_valid   <= 1'b1;
                        r_pslverr <= {2'b00, w_flg};
                    end
                end else begin
                    r_prdata  <= r_valid ? {{(DATA_WIDTH-OW){1'b0}}, r_res} : '0;
                    r_pslverr <= {~r_valid, r_proto, r_flags};
                end
            end
        end
    end

    assign o_PREADY  = r_pready;
    assign o_PRDATA  = r_prdata;
    assign o_PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_exe_unit_2.sv
// Bench for apb_exe_unit_2: directed transfers plus random traffic against an
// arithmetic reference model of the four operations and the flag rules.
module tb_apb_exe_unit_2;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic [2:0] PSEL = '0;
    logic       PENABLE = 1'b0;
    logic       PWRITE = 1'b0;
    logic [1:0] PADDR = '0;
    logic [7:0] PWDATA = '0;
    logic       PREADY;
    logic [7:0] PRDATA;
    logic [3:0] PSLVERR;

    int n_cmp = 0;
    int n_bad = 0;
    int idle_err = 0;

    // reference model state
    int m_res = 0, m_flags = 0, m_prdata = 0;
    bit m_valid = 0;
    logic [7:0] g_rd;
    logic [3:0] g_er;

    apb_exe_unit_2 #(.SEL_WIDTH(3), .ADDR_WIDTH(2), .DATA_WIDTH(8), .SEL_BIT(2)) dut (
        .i_PCLK(PCLK), .i_PRESETn(PRESETn), .i_PSEL(PSEL), .i_PENABLE(PENABLE),
        .i_PWRITE(PWRITE), .i_PADDR(PADDR), .i_PWDATA(PWDATA),
        .o_PREADY(PREADY), .o_PRDATA(PRDATA), .o_PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_exec(input int op, input int d, output int res, output int fl);
        int a, b, as, bs, sgn, n, outb;
        a = d % 16; b = d / 16;
        as = (a >= 8) ? a - 16 : a;
        bs = (b >= 8) ? b - 16 : b;
        res = 0; fl = 0;
        case (op)
            0: begin
                if (as == -8) begin res = 8; fl = 1; end
                else if (as < 0) res = 8 + (-as);
                else res = as;
            end
            1: begin
                sgn = a / 8;
                n = (b < 3) ? b : 3;
                if (b >= 3) begin res = sgn * 8; fl += 2; end
                else res = sgn * 8 + (((a % 8) << b) % 8);
                outb = (a % 8) >> (3 - n);
                if (outb != (sgn ? (1 << n) - 1 : 0)) fl += 1;
            end
            2: res = (as > bs) ? 1 : 0;
            default: for (int i = 0; i < 4; i++) res += (a >> i) & 1;
        endcase
    endfunction

    // One APB transfer starting and ending at a falling edge; PENABLE held 4 cycles.
    task automatic run_xfer(input logic wr, input logic [1:0] addr, input logic [7:0] data,
                            input logic proto, input logic [2:0] sel,
                            output int npulse, output int pidx,
                            output logic [7:0] rd, output logic [3:0] er);
        npulse = 0; pidx = -1; rd = '0; er = '0;
        PSEL = sel; PWRITE = wr; PADDR = addr; PWDATA = data; PENABLE = proto;
        if (!proto) begin
            @(posedge PCLK); #1 PENABLE = 1'b1;
        end
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin PSEL = '0; PENABLE = 1'b0; end
            @(posedge PCLK); @(negedge PCLK);
            if (PREADY) begin
                npulse++; pidx = c; rd = PRDATA; er = PSLVERR;
            end else if (PSLVERR != 4'b0) idle_err++;
        end
    endtask

    task automatic xfer(input string tag, input logic wr, input logic [1:0] addr,
                        input logic [7:0] data, input logic proto, input logic [2:0] sel);
        int np, pi, res, fl, exp_er;
        logic [7:0] rd;
        logic [3:0] er;
        run_xfer(wr, addr, data, proto, sel, np, pi, rd, er);
        g_rd = rd; g_er = er;
        if (!sel[2]) begin
            chk({tag, ".nopulse"}, np, 0);
            return;
        end
        chk({tag, ".pulses"}, np, 1);
        chk({tag, ".pidx"}, pi, 1);
        if (wr) begin
            chk({tag, ".hold"}, rd, m_prdata);
            if (proto) exp_er = 4;
            else begin
                model_exec(addr, data, res, fl);
                m_res = res; m_flags = fl; m_valid = 1;
                exp_er = fl;
            end
            chk({tag, ".werr"}, er, exp_er);
        end else begin
            m_prdata = m_valid ? m_res : 0;
            exp_er = (m_valid ? 0 : 8) + (proto ? 4 : 0) + m_flags;
            chk({tag, ".rdata"}, rd, m_prdata);
            chk({tag, ".rerr"}, er, exp_er);
        end
    endtask

    task automatic model_reset();
        m_res = 0; m_flags = 0; m_prdata = 0; m_valid = 0;
    endtask

    initial begin
        #2;
        chk("rst.pready", PREADY, 0);
        chk("rst.prdata", PRDATA, 0);
        chk("rst.pslverr", PSLVERR, 0);
        @(negedge PCLK); PRESETn = 1'b1;
        @(negedge PCLK);

        xfer("rd0", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.rd0.err", g_er, 4'b1000);

        xfer("shl.w", 1, 2'b01, 8'h1A, 0, 3'b100);
        xfer("shl.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.shl.data", g_rd, 8'h0C);
        chk("plan.shl.err", g_er, 4'b0001);

        xfer("sm.w", 1, 2'b00, 8'h2A, 0, 3'b100);
        xfer("sm.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.sm.data", g_rd, 8'h0E);
        xfer("smmin.w", 1, 2'b00, 8'h08, 0, 3'b100);
        xfer("smmin.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.smmin.data", g_rd, 8'h08);
        chk("plan.smmin.err", g_er, 4'b0001);

        xfer("pop.w", 1, 2'b11, 8'h0A, 0, 3'b100);
        xfer("pop.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.pop.data", g_rd, 8'h02);
        xfer("cmp0.w", 1, 2'b10, 8'h32, 0, 3'b100);
        xfer("cmp0.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.cmp0.data", g_rd, 8'h00);
        xfer("cmp1.w", 1, 2'b10, 8'h23, 0, 3'b100);
        xfer("cmp1.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.cmp1.data", g_rd, 8'h01);

        xfer("shoor.w", 1, 2'b01, 8'h31, 0, 3'b100);
        xfer("shoor.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.shoor.data", g_rd, 8'h00);
        chk("plan.shoor.err1", g_er[1], 1'b1);

        // setup-less write must not touch the result
        xfer("proto.w", 1, 2'b11, 8'h0F, 1, 3'b100);
        chk("plan.proto.err2", g_er[2], 1'b1);
        xfer("proto.r", 0, 2'b00, 8'h00, 1, 3'b100);
        xfer("after.r", 0, 2'b00, 8'h00, 0, 3'b100);

        xfer("unsel.w", 1, 2'b11, 8'h0F, 0, 3'b001);
        xfer("unsel.r", 0, 2'b00, 8'h00, 0, 3'b100);

        // build a non-zero PRDATA, then reset in the middle of a write
        xfer("pre.w", 1, 2'b11, 8'h07, 0, 3'b100);
        xfer("pre.r", 0, 2'b00, 8'h00, 0, 3'b100);
        PSEL = 3'b100; PWRITE = 1'b1; PADDR = 2'b11; PWDATA = 8'h0F;
        @(posedge PCLK); #1 PENABLE = 1'b1;
        @(posedge PCLK); #2 PRESETn = 1'b0;
        #1;
        chk("midrst.pready", PREADY, 0);
        chk("midrst.prdata", PRDATA, 0);
        chk("midrst.pslverr", PSLVERR, 0);
        @(negedge PCLK); PSEL = '0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(negedge PCLK);
        model_reset();
        xfer("postrst.r", 0, 2'b00, 8'h00, 0, 3'b100);
        chk("plan.postrst.err3", g_er[3], 1'b1);

        for (int k = 0; k < 60; k++) begin
            logic       wr, pr;
            logic [1:0] ad;
            logic [7:0] dt;
            logic [2:0] sl;
            wr = 1'($urandom_range(0, 1));
            ad = 2'($urandom_range(0, 3));
            dt = 8'($urandom_range(0, 255));
            pr = ($urandom_range(0, 7) == 0);
            sl = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
            xfer($sformatf("rnd%0d", k), wr, ad, dt, pr, sl);
        end
        xfer("final.r", 0, 2'b00, 8'h00, 0, 3'b100);

        chk("pslverr_when_idle", idle_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_exe_unit_2.md
Name: apb_exe_unit_2

Overview:
- APB slave wrapping a small 4-op execution unit: a write delivers two packed operands and selects the operation by address; a later read returns the registered result.
- Sits on the shared APB bus behind a multi-bit PSEL vector, one unit per PSEL bit.
- Error and status conditions are reported through a 4-bit PSLVERR flag vector.

Parameters:
- SEL_WIDTH, 3, width of the i_PSEL vector.
- ADDR_WIDTH, 2, width of i_PADDR; only bits [1:0] decode the operation, upper bits ignored.
- DATA_WIDTH, 8, width of PWDATA/PRDATA; must be even. Operand width OW = DATA_WIDTH/2.
- SEL_BIT, 0, index of the i_PSEL bit that selects this unit (0 <= SEL_BIT < SEL_WIDTH).

Ports:
- i_PCLK  in  1  clock; all state updates on the rising edge.
- i_PRESETn  in  1  reset; asynchronous, active-low.
- i_PSEL  in  SEL_WIDTH  slave select; unit is selected when i_PSEL[SEL_BIT]=1.
- i_PENABLE  in  1  APB access phase.
- i_PWRITE  in  1  1 = write (execute), 0 = read (fetch result).
- i_PADDR  in  ADDR_WIDTH  operation code on writes; ignored on reads.
- i_PWDATA  in  DATA_WIDTH  operand A = [OW-1:0], operand B = [DATA_WIDTH-1:OW].
- o_PREADY  out  1  registered transfer-complete pulse.
- o_PRDATA  out  DATA_WIDTH  result register.
- o_PSLVERR  out  4  error flags, valid only while o_PREADY=1.

Behaviour:
- Reset (async, i_PRESETn=0): o_PREADY=0, o_PRDATA=0, o_PSLVERR=0, result reg=0, flag reg=0, result_valid=0, FSM=IDLE.
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE -> SETUP when sel & !PENABLE.
  - IDLE -> ACCESS when sel & PENABLE; this is a protocol error and sets PSLVERR[2] for this transfer.
  - SETUP -> ACCESS when sel & PENABLE; SETUP -> IDLE when !sel.
  - ACCESS -> DONE unconditionally after one cycle.
  - DONE -> IDLE when !sel or !PENABLE; otherwise stays in DONE.
- Rising edge in ACCESS:
  - Write: latch A, B and op; compute result and flags into the registers; set result_valid=1. Skipped if PSLVERR[2] is set.
  - Read: o_PRDATA <= result reg.
  - Both: o_PREADY <= 1, o_PSLVERR <= flags.
- o_PREADY is exactly a 1-cycle pulse, i.e. one wait state after the first access cycle. It is not reasserted while PENABLE stays high; it goes high again only after PENABLE or sel drops and a new transfer starts.
- o_PSLVERR is 0 whenever o_PREADY=0. o_PRDATA holds its value until the next read completes.
- Operations (A, B are OW-bit; result is OW bits, zero-extended into DATA_WIDTH):
  - 00 two's-complement to sign-magnitude: A>=0 -> A; A<0 -> {1, |A|}. A = most-negative value -> result {1, 0...0} and PSLVERR[0]=1.
  - 01 sign-preserving left shift by B: result = {A[OW-1], (A[OW-2:0] << B) truncated to OW-1 bits}. PSLVERR[0]=1 if any bit shifted out of A[OW-2:0] differs from A[OW-1]. PSLVERR[1]=1 if B >= OW-1; in that case the magnitude field = 0.
  - 10 signed compare: result = 1 if A > B (signed), else 0.
  - 11 population count of A.
- Flags: [0] overflow/unrepresentable; [1] shift amount out of range; [2] protocol error; [3] read with result_valid=0 (o_PRDATA returns 0).
- Write transfers complete with o_PSLVERR = flags of the operation just computed. Read transfers report the flags stored by the last write, plus [3] and [2] when applicable.
- Reset asserted mid-transfer aborts the transfer immediately; no partial result is kept.
- Unselected cycles (i_PSEL[SEL_BIT]=0) never change the result register or outputs other than clearing the o_PREADY pulse.

Test Plan:
- Setup: SEL_BIT=2, DATA_WIDTH=8. Every transfer: 1 setup cycle, then PENABLE held for 4 cycles, PSEL=3'b100.
- Reset, then read -> PREADY pulses once; PRDATA=0x00; PSLVERR=4'b1000.
- Write addr 01, data 0x1A (A=1010, B=1), then read -> PRDATA=0x0C, PSLVERR[0]=1. PREADY pulses exactly once per transfer despite 4 cycles of PENABLE.
- Write addr 00, data 0x2A (A=-6), then read -> PRDATA=0x0E, PSLVERR=0. Also write data 0x08 -> PRDATA=0x08, PSLVERR[0]=1.
- Write addr 11, data 0x0A -> read PRDATA=0x02. Write addr 10, data 0x32 -> PRDATA=0x00; data 0x23 -> PRDATA=0x01.
- Write addr 01, data 0x31 (B=3) -> PSLVERR[1]=1, PRDATA=0x00.
- Protocol checks: PSEL+PENABLE asserted together from IDLE -> PSLVERR[2]=1 and result unchanged. PSEL=3'b001 -> no PREADY. PRESETn pulsed low during ACCESS -> all outputs 0 at once; next read gives PSLVERR[3]=1.
